// File: rtl/mfp_irq_ctrl.sv
// MC68901-style prioritised interrupt controller: per-source edge detection, pending/in-service
// tracking, vectored acknowledge. Define MFP_IRQ_LEVEL_EN to enable per-source level sensitivity.
module mfp_irq_ctrl #(
    parameter int          NUM_SRC  = 16,
    parameter logic [7:0]  SPUR_VEC = 8'h18
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk_en,
    input  logic               sel,
    input  logic [4:0]         addr,
    input  logic [7:0]         din,
    input  logic               ds,
    input  logic               rw,
    output logic [7:0]         dout,
    output logic               dtack,
    input  logic [NUM_SRC-1:0] src,
    input  logic               iack,
    output logic               irq
);
    localparam int NB = NUM_SRC / 8;
    localparam int IW = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0] ier_reg, ipr_reg, isr_reg, imr_reg, aer_reg, a_d_reg;
    logic [NUM_SRC-1:0] ier_next, ipr_next, isr_next, imr_next, aer_next;
    logic [NUM_SRC-1:0] lvl_reg;
    logic [7:0]         vr_reg, vr_next, vec_reg, vec_next;
    logic               sel_reg, iack_reg;

    logic [NUM_SRC-1:0] act, edge_det, pend, ipr_clr, isr_clr, p_hot, ipr_edge;
    logic [NB-1:0]      bank_hit;
    logic [IW-1:0]      p_idx, s_idx;
    logic               pv, sv, wr_stb, iack_stb;
    logic [7:0]         rd_data, vec_calc;

    // Bank decode shared by the read mux and the write decoder; banks past NB never match.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_bank
            assign bank_hit[gi] = (addr[1:0] == 2'(gi));
        end
    endgenerate

    assign wr_stb   = clk_en & sel & ~ds & ~rw & ~sel_reg;
    assign iack_stb = clk_en & iack & ~iack_reg & ~ds;
    assign act      = src ^ ~aer_reg;
    assign edge_det = act & ~a_d_reg;
    assign pend     = ipr_reg & imr_reg;

    always_comb begin
        p_idx = '0;
        pv    = 1'b0;
        s_idx = '0;
        sv    = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pend[i]) begin
                p_idx = IW'(i);
                pv    = 1'b1;
            end
            if (isr_reg[i]) begin
                s_idx = IW'(i);
                sv    = 1'b1;
            end
        end
    end

    assign irq   = pv & (~sv | (p_idx > s_idx));
    assign p_hot = (iack_stb & pv) ? (NUM_SRC'(1) << p_idx) : '0;

    always_comb begin
        vec_calc            = vr_reg;
        vec_calc[IW-1:0]    = p_idx;
    end

`ifdef MFP_IRQ_LEVEL_EN
    logic [NUM_SRC-1:0] lvl_next;
`else
    assign lvl_reg = '0;
`endif

    always_comb begin
        ier_next = ier_reg;
        imr_next = imr_reg;
        aer_next = aer_reg;
        vr_next  = vr_reg;
        ipr_clr  = '0;
        isr_clr  = '0;
`ifdef MFP_IRQ_LEVEL_EN
        lvl_next = lvl_reg;
`endif
        if (wr_stb) begin
            if (addr == 5'h14)
                vr_next = din;
            for (int b = 0; b < NB; b++) begin
                if (bank_hit[b]) begin
                    case (addr[4:2])
                        3'd0: begin
                            ier_next[8*b +: 8] = din;
                            ipr_clr[8*b +: 8]  = ~din;
                        end
                        3'd1: ipr_clr[8*b +: 8]  = ~din;
                        3'd2: isr_clr[8*b +: 8]  = ~din;
                        3'd3: imr_next[8*b +: 8] = din;
                        3'd4: aer_next[8*b +: 8] = din;
`ifdef MFP_IRQ_LEVEL_EN
                        3'd6: lvl_next[8*b +: 8] = din;
`endif
                        default: ;
                    endcase
                end
            end
        end
    end

    // A new edge outranks any same-cycle clear; level sources simply track the qualified input.
    assign ipr_edge = (ipr_reg & ~ipr_clr & ~p_hot) | (edge_det & ier_reg);
    assign ipr_next = (ipr_edge & ~lvl_reg) | (act & ier_reg & lvl_reg);
    assign isr_next = (isr_reg & ~isr_clr) | (vr_reg[3] ? p_hot : '0);
    assign vec_next = iack_stb ? (pv ? vec_calc : SPUR_VEC) : vec_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            ier_reg  <= '0;
            ipr_reg  <= '0;
            isr_reg  <= '0;
            imr_reg  <= '0;
            aer_reg  <= '0;
            a_d_reg  <= '0;
            vr_reg   <= '0;
            vec_reg  <= '0;
            sel_reg  <= 1'b0;
            iack_reg <= 1'b0;
        end else if (clk_en) begin
            ier_reg  <= ier_next;
            ipr_reg  <= ipr_next;
            isr_reg  <= isr_next;
            imr_reg  <= imr_next;
            aer_reg  <= aer_next;
            a_d_reg  <= act;
            vr_reg   <= vr_next;
            vec_reg  <= vec_next;
            sel_reg  <= sel;
            iack_reg <= iack;
        end
    end

`ifdef MFP_IRQ_LEVEL_EN
    always_ff @(posedge clk) begin
        if (reset)
            lvl_reg <= '0;
        else if (clk_en)
            lvl_reg <= lvl_next;
    end
`endif

    always_comb begin
        rd_data = '0;
        if (addr == 5'h14)
            rd_data = vr_reg;
        for (int b = 0; b < NB; b++) begin
            if (bank_hit[b]) begin
                case (addr[4:2])
                    3'd0:    rd_data = ier_reg[8*b +: 8];
                    3'd1:    rd_data = ipr_reg[8*b +: 8];
                    3'd2:    rd_data = isr_reg[8*b +: 8];
                    3'd3:    rd_data = imr_reg[8*b +: 8];
                    3'd4:    rd_data = aer_reg[8*b +: 8];
                    3'd6:    rd_data = lvl_reg[8*b +: 8];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        dout = 8'h00;
        if (sel && !ds && rw)
            dout = rd_data;
        else if (iack)
            dout = vec_reg;
    end

    assign dtack = (sel_reg & sel) | (iack_reg & iack);

endmodule

// File: tb/tb_mfp_irq_ctrl.sv
// Directed bench for mfp_irq_ctrl: a 16-source and a 32-source instance on a shared CPU bus.
module tb_mfp_irq_ctrl;
    logic        clk = 1'b0;
    logic        reset, clk_en;
    logic [4:0]  addr;
    logic [7:0]  din;
    logic        ds, rw;
    logic        sel16, sel32, iack16, iack32;
    logic [15:0] src16;
    logic [31:0] src32;
    logic [7:0]  dout16, dout32;
    logic        dtack16, dtack32, irq16, irq32;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mfp_irq_ctrl #(.NUM_SRC(16), .SPUR_VEC(8'h18)) dut16 (
        .clk(clk), .reset(reset), .clk_en(clk_en), .sel(sel16), .addr(addr), .din(din),
        .ds(ds), .rw(rw), .dout(dout16), .dtack(dtack16), .src(src16), .iack(iack16), .irq(irq16)
    );

    mfp_irq_ctrl #(.NUM_SRC(32), .SPUR_VEC(8'h18)) dut32 (
        .clk(clk), .reset(reset), .clk_en(clk_en), .sel(sel32), .addr(addr), .din(din),
        .ds(ds), .rw(rw), .dout(dout32), .dtack(dtack32), .src(src32), .iack(iack32), .irq(irq32)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-14s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wr(input bit w32, input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; din = d; rw = 1'b0; ds = 1'b0;
        if (w32) sel32 = 1'b1; else sel16 = 1'b1;
        @(negedge clk);
        sel16 = 1'b0; sel32 = 1'b0; ds = 1'b1; rw = 1'b1;
    endtask

    task automatic rd(input bit w32, input string tag, input logic [4:0] a, input logic [7:0] exp);
        @(negedge clk);
        addr = a; rw = 1'b1; ds = 1'b0;
        if (w32) sel32 = 1'b1; else sel16 = 1'b1;
        #1;
        chk(tag, w32 ? dout32 : dout16, exp);
        sel16 = 1'b0; sel32 = 1'b0; ds = 1'b1;
    endtask

    task automatic ack(input bit w32, input string tag, input logic [7:0] exp);
        @(negedge clk);
        ds = 1'b0;
        if (w32) iack32 = 1'b1; else iack16 = 1'b1;
        @(negedge clk);
        chk(tag, w32 ? dout32 : dout16, exp);
        iack16 = 1'b0; iack32 = 1'b0; ds = 1'b1;
    endtask

    initial begin
        reset = 1'b1; clk_en = 1'b1; addr = '0; din = '0; ds = 1'b1; rw = 1'b1;
        sel16 = 1'b0; sel32 = 1'b0; iack16 = 1'b0; iack32 = 1'b0; src16 = '0; src32 = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_irq", irq16, 1'b0);
        chk("rst_dtack", dtack16, 1'b0);
        chk("rst_dout", dout16, 8'h00);
        rd(1'b0, "rst_ier", 5'h00, 8'h00);

        // 32-source instance: top source vector composition
        wr(1'b1, 5'h03, 8'h80);
        wr(1'b1, 5'h0F, 8'h80);
        wr(1'b1, 5'h13, 8'h80);
        wr(1'b1, 5'h14, 8'hA0);
        @(negedge clk); src32[31] = 1'b1;
        @(negedge clk);
        chk("irq32", irq32, 1'b1);
        ack(1'b1, "vec32", 8'hBF);
        rd(1'b1, "ier32_b3", 5'h03, 8'h80);
        rd(1'b1, "isr32_b3", 5'h0B, 8'h00);

        // dtack follows registered sel
        @(negedge clk);
        addr = 5'h00; rw = 1'b1; ds = 1'b0; sel16 = 1'b1;
        chk("dtack_first", dtack16, 1'b0);
        @(negedge clk);
        chk("dtack_held", dtack16, 1'b1);
        sel16 = 1'b0; ds = 1'b1;

        wr(1'b0, 5'h00, 8'hFF); wr(1'b0, 5'h01, 8'hFF);
        wr(1'b0, 5'h0C, 8'hFF); wr(1'b0, 5'h0D, 8'hFF);
        wr(1'b0, 5'h10, 8'hFF); wr(1'b0, 5'h11, 8'hFF);
        wr(1'b0, 5'h14, 8'h48);
        rd(1'b0, "ipr_idle", 5'h04, 8'h00);

        @(negedge clk); src16[5] = 1'b1;
        @(negedge clk);
        chk("irq_src5", irq16, 1'b1);
        rd(1'b0, "ipr_src5", 5'h04, 8'h20);
        ack(1'b0, "vec_src5", 8'h45);
        chk("irq_svc5", irq16, 1'b0);
        rd(1'b0, "isr_src5", 5'h08, 8'h20);
        rd(1'b0, "ipr_clr5", 5'h04, 8'h00);

        // lower priority blocked by in-service source, higher one preempts
        @(negedge clk); src16[3] = 1'b1;
        @(negedge clk);
        chk("irq_src3", irq16, 1'b0);
        rd(1'b0, "ipr_src3", 5'h04, 8'h08);
        @(negedge clk); src16[9] = 1'b1;
        @(negedge clk);
        chk("irq_src9", irq16, 1'b1);
        ack(1'b0, "vec_src9", 8'h49);
        rd(1'b0, "isr_hi", 5'h09, 8'h02);
        wr(1'b0, 5'h09, 8'h00); wr(1'b0, 5'h08, 8'h00);
        @(negedge clk);
        chk("irq_src3_ok", irq16, 1'b1);
        ack(1'b0, "vec_src3", 8'h43);
        wr(1'b0, 5'h08, 8'hFF);
        rd(1'b0, "isr_w1_keep", 5'h08, 8'h08);
        wr(1'b0, 5'h14, 8'h40);
        rd(1'b0, "isr_aeoi_keep", 5'h08, 8'h08);
        wr(1'b0, 5'h08, 8'h00);
        rd(1'b0, "isr_cleared", 5'h08, 8'h00);

        // automatic EOI, source 0
        @(negedge clk); src16[0] = 1'b1;
        @(negedge clk);
        chk("irq_src0", irq16, 1'b1);
        ack(1'b0, "vec_src0_a", 8'h40);
        @(negedge clk); src16[0] = 1'b0;
        @(negedge clk); src16[0] = 1'b1;
        ack(1'b0, "vec_src0_b", 8'h40);
        rd(1'b0, "isr_aeoi_lo", 5'h08, 8'h00);
        rd(1'b0, "isr_aeoi_hi", 5'h09, 8'h00);

        // IPR clear write coinciding with an edge: edge wins
        @(negedge clk);
        src16[2] = 1'b1; addr = 5'h04; din = 8'h00; rw = 1'b0; ds = 1'b0; sel16 = 1'b1;
        @(negedge clk);
        sel16 = 1'b0; ds = 1'b1; rw = 1'b1;
        rd(1'b0, "ipr_setwins", 5'h04, 8'h04);
        ack(1'b0, "vec_src2", 8'h42);
        rd(1'b0, "ipr_after2", 5'h04, 8'h00);
        ack(1'b0, "vec_spur", 8'h18);

        @(negedge clk); src16[6] = 1'b1;
        rd(1'b0, "ipr_src6", 5'h04, 8'h40);
        wr(1'b0, 5'h04, 8'hFF);
        rd(1'b0, "ipr_w1_keep", 5'h04, 8'h40);
        wr(1'b0, 5'h04, 8'hBF);
        rd(1'b0, "ipr_w0_clr", 5'h04, 8'h00);

        @(negedge clk); src16[7] = 1'b1;
        rd(1'b0, "ipr_src7", 5'h04, 8'h80);
        wr(1'b0, 5'h00, 8'h7F);
        rd(1'b0, "ier_w", 5'h00, 8'h7F);
        rd(1'b0, "ipr_ier_clr", 5'h04, 8'h00);
        wr(1'b0, 5'h00, 8'hFF);

        // AER change that activates a held level counts as an edge
        wr(1'b0, 5'h10, 8'hEF);
        rd(1'b0, "ipr_aer_edge", 5'h04, 8'h10);
        wr(1'b0, 5'h10, 8'hFF);
        wr(1'b0, 5'h04, 8'hEF);
        rd(1'b0, "ipr_aer_clr", 5'h04, 8'h00);

        wr(1'b0, 5'h02, 8'hFF);
        rd(1'b0, "bank2_unmap", 5'h02, 8'h00);
        rd(1'b0, "addr15_unmap", 5'h15, 8'h00);
        rd(1'b0, "addr1c_unmap", 5'h1C, 8'h00);
        rd(1'b0, "vr_read", 5'h14, 8'h40);

`ifdef MFP_IRQ_LEVEL_EN
        wr(1'b0, 5'h18, 8'h02);
        rd(1'b0, "lvl_read", 5'h18, 8'h02);
        @(negedge clk); src16[1] = 1'b1;
        rd(1'b0, "ipr_lvl_on", 5'h04, 8'h02);
        ack(1'b0, "vec_lvl", 8'h41);
        rd(1'b0, "ipr_lvl_hold", 5'h04, 8'h02);
        @(negedge clk); src16[1] = 1'b0;
        rd(1'b0, "ipr_lvl_off", 5'h04, 8'h00);
        wr(1'b0, 5'h18, 8'h00);
`else
        wr(1'b0, 5'h18, 8'hFF);
        rd(1'b0, "lvl_ignored", 5'h18, 8'h00);
`endif

        // state frozen while clk_en is low
        @(negedge clk); clk_en = 1'b0; src16[8] = 1'b1;
        repeat (3) @(negedge clk);
        rd(1'b0, "ipr_clken_lo", 5'h05, 8'h00);
        chk("irq_clken_lo", irq16, 1'b0);
        clk_en = 1'b1;
        rd(1'b0, "ipr_clken_hi", 5'h05, 8'h01);

        // reset during an acknowledge
        @(negedge clk);
        ds = 1'b0; iack16 = 1'b1; reset = 1'b1;
        @(negedge clk);
        chk("rstack_vec", dout16, 8'h00);
        chk("rstack_dtack", dtack16, 1'b0);
        chk("rstack_irq", irq16, 1'b0);
        reset = 1'b0; iack16 = 1'b0; ds = 1'b1;
        rd(1'b0, "rst_ier_again", 5'h00, 8'h00);
        rd(1'b0, "rst_vr", 5'h14, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mfp_irq_ctrl.md
MFP_IRQ_CTRL -- requirements
Module: mfp_irq_ctrl

Interface
REQ-001 Clocking SHALL be one clock; reset SHALL be synchronous and active-high.
REQ-002 Parameter NUM_SRC, default 16: number of interrupt sources; legal values 8, 16, 24 or 32.
REQ-003 Parameter SPUR_VEC, default 8'h18: vector returned on an IACK cycle with nothing pending.
REQ-004 Port clk, input, 1 bit: system clock.
REQ-005 Port reset, input, 1 bit: synchronous active-high reset.
REQ-006 Port clk_en, input, 1 bit: bus-cycle enable; all state except reset advances only when high.
REQ-007 CPU bus ports: sel in 1; addr in 5; din in 8; ds in 1 (active-low); rw in 1 (1 = read); dout out 8; dtack out 1.
REQ-008 Port src, input, NUM_SRC bits: raw interrupt inputs; higher index has higher priority.
REQ-009 Port iack, input, 1 bit: interrupt acknowledge cycle in progress.
REQ-010 Port irq, output, 1 bit: interrupt request to the CPU, active-high.

Function
REQ-011 Notation: NB = NUM_SRC/8; bank b covers src[8b+7:8b]; IW = log2 of NUM_SRC rounded up.
REQ-012 Register map, per bank b < NB: IER 0x00+b, IPR 0x04+b, ISR 0x08+b, IMR 0x0C+b, AER 0x10+b, LVL 0x18+b; VR at 0x14.
REQ-013 Unmapped addresses and banks >= NB SHALL read 0; writes to them SHALL be ignored.
REQ-014 Write strobe: exactly one pulse, on the first clk_en cycle with sel=1, ds=0, rw=0 while sel was 0 on the previous clk_en.
REQ-015 dtack = (sel registered on clk_en AND sel) OR (iack registered on clk_en AND iack).
REQ-016 Reads are combinational: when sel=1, ds=0, rw=1, dout = addressed register; else, when iack=1, dout = latched vector; else dout = 0.
REQ-017 Edge detection: each clk_en, per source, a = src XOR NOT aer and a_d = a registered; edge = a AND NOT a_d.
REQ-018 An AER write that makes an input's current level active SHALL count as an edge (MC68901 behaviour).
REQ-019 Edge mode: edge with IER bit set SHALL set the IPR bit on that same clk_en.
REQ-020 Edge mode: writing 0 to an IPR bit clears it; writing 1 leaves it unchanged.
REQ-021 Writing 0 to an IER bit SHALL clear the IER bit and the corresponding IPR bit.
REQ-022 If a set and a clear of the same IPR bit occur on the same clk_en, set wins.
REQ-023 Writing 0 to an ISR bit clears it; writing 1 leaves it unchanged.
REQ-024 Pending index P = highest index with IPR AND IMR set; Pv = 1 when such an index exists.
REQ-025 Service index S = highest index with ISR set; Sv = 1 when such an index exists.
REQ-026 irq = Pv AND (NOT Sv OR P > S), combinational; source 0 SHALL be serviceable when ISR is empty.
REQ-027 IACK strobe: clk_en AND iack AND NOT (iack registered on clk_en) AND NOT ds.
REQ-028 On IACK strobe with Pv=1: the vector latches to VR[7:IW] concatenated with P; IPR[P] clears (edge mode); ISR[P] sets only if VR[3]=1.
REQ-029 On IACK strobe with Pv=0: the vector latches SPUR_VEC; IPR and ISR are unchanged.
REQ-030 The vector SHALL stay stable until the next IACK strobe.
REQ-031 VR[3]=0 (automatic EOI): ISR never sets; writing VR[3]=0 does not clear ISR bits already set.

Reset
REQ-032 Reset SHALL clear IER, IPR, ISR, IMR, AER, LVL, VR, the latched vector, the edge history and the registered sel/iack.
REQ-033 Consequently irq=0 and dtack=0 on the first cycle after reset.
REQ-034 Reset SHALL take effect regardless of clk_en.
REQ-035 Reset asserted mid-IACK SHALL abort the acknowledge; after reset the vector reads 0.

Configuration
REQ-036 Macro MFP_IRQ_LEVEL_EN defined: an LVL bit of 1 makes that source level-sensitive.
REQ-037 Level mode: each clk_en, IPR = a AND IER; IACK and CPU writes do not clear it; ISR handling is unchanged.
REQ-038 Macro MFP_IRQ_LEVEL_EN undefined: LVL registers read 0, writes to them are ignored, and all sources are edge mode.

Verification
REQ-039 NUM_SRC=16; IER=IMR=0xFFFF; AER=0xFFFF; src[5] 0->1; VR=0x48; IACK -> irq=1 one clk_en after the edge; dout=0x45; ISR[5]=1; IPR[5]=0; irq=0.
REQ-040 ISR[5] set; raise src[3], then src[9] -> irq stays 0 for source 3; irq=1 for source 9; IACK vector 0x49.
REQ-041 VR=0x40 (automatic EOI); two edges on src[0]; two IACKs -> both vectors 0x40; ISR stays 0x0000.
REQ-042 Write IPR low byte 0x00 on the same clk_en as an edge on src[2] -> IPR[2]=1 (set wins); IACK with nothing pending -> dout=0x18.
REQ-043 NUM_SRC=32; VR=0xA0; edge on src[31] -> vector 0xBF; address 0x03 (IER bank 3) reads back its written value.
REQ-044 MFP_IRQ_LEVEL_EN defined; LVL[1]=1; hold src[1]=1 through IACK -> IPR[1] stays 1; drop src[1] -> IPR[1]=0 on the next clk_en.
